// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the E-stage multiply/divide unit.
// Optional MDU_MADD_EN adds MADD/MADDU to the accepted md_start operations.
package mdu_pkg;

  typedef logic [3:0] md_op_t;

  localparam md_op_t OP_NONE  = 4'd0;
  localparam md_op_t OP_MULT  = 4'd1;
  localparam md_op_t OP_MULTU = 4'd2;
  localparam md_op_t OP_DIV   = 4'd3;
  localparam md_op_t OP_DIVU  = 4'd4;
  localparam md_op_t OP_MFHI  = 4'd5;
  localparam md_op_t OP_MFLO  = 4'd6;
  localparam md_op_t OP_MTHI  = 4'd7;
  localparam md_op_t OP_MTLO  = 4'd8;
  localparam md_op_t OP_MADD  = 4'd9;
  localparam md_op_t OP_MADDU = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_div_op(input md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Operations that start a multi-cycle run when md_start is set.
  function automatic logic is_start_op(input md_op_t op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: ok = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU:                  ok = 1'b1;
`endif
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit {HI,LO} result for the operation being accepted.
// With MDU_MADD_EN defined, MADD/MADDU accumulate onto the current {HI,LO}.
module mdu_calc
  import mdu_pkg::*;
(
  input  md_op_t      md_op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] res_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_rs;
  logic [31:0] abs_rt;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic        div0;

  // Low 64 bits of a sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
  assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

  // Signed divide on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
  assign abs_rs = rs_i[31] ? 32'(-rs_i) : rs_i;
  assign abs_rt = rt_i[31] ? 32'(-rt_i) : rt_i;
  assign q_mag  = abs_rs / abs_rt;
  assign r_mag  = abs_rs % abs_rt;
  assign q_s    = (rs_i[31] ^ rt_i[31]) ? 32'(-q_mag) : q_mag;
  assign r_s    = rs_i[31] ? 32'(-r_mag) : r_mag;
  assign div0   = (rt_i == 32'd0);

  always_comb begin
    res_o = {hi_i, lo_i};
    case (md_op_i)
      OP_MULT:  res_o = prod_s;
      OP_MULTU: res_o = prod_u;
      OP_DIV:   if (!div0) res_o = {r_s, q_s};
      OP_DIVU:  if (!div0) res_o = {rs_i % rt_i, rs_i / rt_i};
`ifdef MDU_MADD_EN
      OP_MADD:  res_o = {hi_i, lo_i} + prod_s;
      OP_MADDU: res_o = {hi_i, lo_i} + prod_u;
`endif
      default:  res_o = {hi_i, lo_i};
    endcase
  end

endmodule

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: HI/LO ownership, busy FSM and mfhi/mflo read.
// Build option MDU_MADD_EN enables MADD/MADDU (handled in mdu_pkg/mdu_calc).
module mdu_e
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  md_op_t      md_op,
  input  logic        md_start,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        exc_cancel,
  output logic        busy,
  output logic [31:0] md_out
);

  localparam int unsigned CNT_W = $clog2(max_u(MULT_CYCLES, DIV_CYCLES) + 1);

  mdu_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] tmp_q, tmp_d;
  logic [63:0] calc_res;

  mdu_calc u_calc (
    .md_op_i (md_op),
    .rs_i    (rs_data),
    .rt_i    (rt_data),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .res_o   (calc_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      tmp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      tmp_q   <= tmp_d;
    end
  end

  // Next-state: accept / mthi / mtlo in IDLE, countdown and commit in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    tmp_d   = tmp_q;
    case (state_q)
      ST_IDLE: begin
        if (md_start && !exc_cancel && is_start_op(md_op)) begin
          tmp_d   = calc_res;
          cnt_d   = is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d = ST_BUSY;
        end else if (!exc_cancel) begin
          if (md_op == OP_MTHI) hi_d = rs_data;
          if (md_op == OP_MTLO) lo_d = rs_data;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = tmp_q[63:32];
          lo_d    = tmp_q[31:0];
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_BUSY);

  always_comb begin
    md_out = 32'd0;
    case (md_op)
      OP_MFHI: md_out = hi_q;
      OP_MFLO: md_out = lo_q;
      default: md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_e.sv
// Self-checking bench for mdu_e: directed cases plus randomized ops against a
// plain-arithmetic HI/LO model (follows MDU_MADD_EN like the design).
module tb_mdu_e;
  import mdu_pkg::*;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk;
  logic        reset;
  md_op_t      md_op;
  logic        md_start;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        exc_cancel;
  logic        busy;
  logic [31:0] md_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_e #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk        (clk),
    .reset      (reset),
    .md_op      (md_op),
    .md_start   (md_start),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .exc_cancel (exc_cancel),
    .busy       (busy),
    .md_out     (md_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_accepts(input md_op_t op);
    logic ok;
    ok = (op >= 4'd1) && (op <= 4'd4);
`ifdef MDU_MADD_EN
    if (op == 4'd9 || op == 4'd10) ok = 1'b1;
`endif
    return ok;
  endfunction

  function automatic int unsigned model_latency(input md_op_t op);
    return (op == OP_DIV || op == OP_DIVU) ? DIV_N : MULT_N;
  endfunction

  task automatic model_exec(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sp;
    longint unsigned ua, ub, up, acc;
    ia  = a;
    ib  = b;
    ua  = a;
    ub  = b;
    sp  = longint'(ia) * longint'(ib);
    up  = ua * ub;
    acc = {m_hi, m_lo};
    case (op)
      OP_MULT:  {m_hi, m_lo} = sp;
      OP_MULTU: {m_hi, m_lo} = up;
      OP_DIV: if (b != 32'd0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'd0;
        end else begin
          m_lo = ia / ib;
          m_hi = ia % ib;
        end
      end
      OP_DIVU: if (b != 32'd0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      OP_MADD:  {m_hi, m_lo} = acc + sp;
      OP_MADDU: {m_hi, m_lo} = acc + up;
      default: ;
    endcase
  endtask

  task automatic check_hilo(input string tag);
    md_op = OP_MFHI;
    #1;
    check32({tag, ".hi"}, md_out, m_hi);
    md_op = OP_MFLO;
    #1;
    check32({tag, ".lo"}, md_out, m_lo);
    md_op = OP_NONE;
    #1;
  endtask

  task automatic run_md(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic cancel, input string tag);
    int   cnt;
    logic acc;
    acc        = model_accepts(op) && !cancel;
    md_op      = op;
    md_start   = 1'b1;
    rs_data    = a;
    rt_data    = b;
    exc_cancel = cancel;
    step();
    md_start   = 1'b0;
    md_op      = OP_NONE;
    exc_cancel = 1'b0;
    cnt = 0;
    while (busy && cnt < 64) begin
      cnt++;
      step();
    end
    check32({tag, ".busy_cycles"}, 32'(cnt), acc ? 32'(model_latency(op)) : 32'd0);
    if (acc) model_exec(op, a, b);
    check_hilo(tag);
  endtask

  task automatic write_hl(input md_op_t op, input logic [31:0] val, input logic cancel,
                          input string tag);
    md_op      = op;
    rs_data    = val;
    exc_cancel = cancel;
    step();
    md_op      = OP_NONE;
    exc_cancel = 1'b0;
    if (!cancel) begin
      if (op == OP_MTHI) m_hi = val;
      else               m_lo = val;
    end
    check_hilo(tag);
  endtask

  initial begin
    int   cnt;
    md_op_t ops [10];
    md_op_t op;
    logic [31:0] a, b;
    logic        c;

    reset      = 1'b0;
    md_op      = OP_NONE;
    md_start   = 1'b0;
    rs_data    = 32'd0;
    rt_data    = 32'd0;
    exc_cancel = 1'b0;
    m_hi       = 32'd0;
    m_lo       = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst.busy", 32'(busy), 32'd0);
    check32("rst.md_out", md_out, 32'd0);
    check_hilo("rst");
    reset = 1'b1;
    step();

    run_md(OP_MULT,  32'hFFFF_FFFE, 32'd3,        1'b0, "mult");
    run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu");
    run_md(OP_DIV,   32'hFFFF_FFF9, 32'd2,        1'b0, "div_neg");
    run_md(OP_DIVU,  32'd7,         32'd2,        1'b0, "divu");
    run_md(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");

    write_hl(OP_MTHI, 32'h11, 1'b0, "mthi");
    write_hl(OP_MTLO, 32'h22, 1'b0, "mtlo");
    run_md(OP_DIVU, 32'd1234, 32'd0, 1'b0, "divu_zero");
    run_md(OP_DIV,  32'd99,   32'd0, 1'b0, "div_zero");

    run_md(OP_MULT, 32'd5, 32'd6, 1'b1, "mult_cancel");
    write_hl(OP_MTHI, 32'h5, 1'b1, "mthi_cancel");

    md_op = 4'd12;
    #1;
    check32("op12.md_out", md_out, 32'd0);
    md_op = OP_NONE;

    // A second md_start in the middle of a run must be dropped.
    md_op    = OP_MULT;
    md_start = 1'b1;
    rs_data  = 32'd3;
    rt_data  = 32'd4;
    step();
    md_start = 1'b0;
    md_op    = OP_NONE;
    cnt = 0;
    while (busy && cnt < 64) begin
      cnt++;
      if (cnt == 2) begin
        md_op    = OP_DIV;
        md_start = 1'b1;
        rs_data  = 32'd100;
        rt_data  = 32'd7;
      end else begin
        md_start = 1'b0;
        md_op    = OP_NONE;
      end
      step();
    end
    md_start = 1'b0;
    md_op    = OP_NONE;
    check32("overlap.busy_cycles", 32'(cnt), 32'(MULT_N));
    model_exec(OP_MULT, 32'd3, 32'd4);
    check_hilo("overlap");
    step();
    check32("overlap.busy_after", 32'(busy), 32'd0);

    write_hl(OP_MTHI, 32'd0,         1'b0, "madd_prehi");
    write_hl(OP_MTLO, 32'hFFFF_FFFF, 1'b0, "madd_prelo");
    run_md(OP_MADDU, 32'd1, 32'd1, 1'b0, "maddu");

    // Reset in the third busy cycle of a divide discards it.
    write_hl(OP_MTHI, 32'hAA, 1'b0, "midrst_pre");
    md_op    = OP_DIV;
    md_start = 1'b1;
    rs_data  = 32'd100;
    rt_data  = 32'd7;
    step();
    md_start = 1'b0;
    md_op    = OP_NONE;
    step();
    step();
    check32("midrst.busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check32("midrst.busy", 32'(busy), 32'd0);
    check_hilo("midrst");
    reset = 1'b1;
    repeat (DIV_N + 2) step();
    check32("midrst.busy_after", 32'(busy), 32'd0);
    check_hilo("midrst_after");

    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO,
            OP_MADD, OP_MADDU, OP_DIV, OP_DIVU};
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 9)];
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'(32'($urandom_range(0, 3)));
        1:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      c = ($urandom_range(0, 7) == 0);
      if (op == OP_MTHI || op == OP_MTLO) write_hl(op, a, c, "rnd_mt");
      else                                run_md(op, a, b, c, "rnd_md");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_e.md
# mdu_e

E-stage multiply/divide unit of the five-stage MIPS pipeline. It owns the HI/LO registers and executes mult/multu/div/divu as multi-cycle operations behind a busy flag, applies mthi/mtlo writes, and supplies the combinational HI/LO read for mfhi/mflo. Its md_out result is registered into the E/M pipeline register. The M-stage control unit selects that registered value for writeback when it decodes mfhi/mflo.

## Interface
- MULT_CYCLES, 5, busy duration of mult/multu (and madd/maddu)
- DIV_CYCLES, 10, busy duration of div/divu

- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- md_op  in  4  decoded E-stage operation (encodings in mdu_pkg)
- md_start  in  1  E-stage instruction is mult/multu/div/divu (or madd/maddu)
- rs_data  in  32  forwarded rs operand
- rt_data  in  32  forwarded rt operand
- exc_cancel  in  1  M-stage exception/eret flush; E instruction must not commit
- busy  out  1  multi-cycle operation in flight
- md_out  out  32  HI when md_op=MFHI, LO when md_op=MFLO, else 0

## Operation
- md_op encodings:
  - NONE=0
  - MULT=1
  - MULTU=2
  - DIV=3
  - DIVU=4
  - MFHI=5
  - MFLO=6
  - MTHI=7
  - MTLO=8
  - MADD=9
  - MADDU=10
  - 11–15 behave as NONE.
- States: IDLE, BUSY. Counter width ceil(log2(max(MULT_CYCLES, DIV_CYCLES)+1)).
- Accept: in IDLE with md_start=1 and exc_cancel=0.
  - Result is computed from rs_data/rt_data at the accept edge and held in tmp_hi/tmp_lo.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES; state goes to BUSY.
- BUSY: counter decrements each edge. At the edge where counter==1, HI/LO are loaded from tmp and the state returns to IDLE.
- md_start while BUSY: ignored. The hazard unit stalls D while (md_start|busy) and the D instruction is md-class.
- Arithmetic:
  - MULT: signed 32x32, 64-bit product; {HI,LO}=product.
  - MULTU: unsigned 32x32, 64-bit product; {HI,LO}=product.
  - DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: LO=quotient, HI=remainder, unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0: op is still accepted and busy runs DIV_CYCLES; HI/LO are left unchanged at completion.
- MTHI/MTLO:
  - Write HI/LO from rs_data at the edge when md_op matches, exc_cancel=0 and busy=0.
  - Ignored while busy.
- exc_cancel=1 suppresses accept and MTHI/MTLO in that cycle. An operation already in BUSY continues and completes, because it belongs to an older, committed instruction.
- md_out is purely combinational from current HI/LO. The hazard unit guarantees mfhi/mflo never reaches E while busy=1.

## Timing
- Reset (reset=0):
  - HI=0, LO=0, tmp_hi=0, tmp_lo=0.
  - counter=0, state=IDLE.
  - busy=0, md_out=0 (provided md_op is not MFHI/MFLO).
- Accept at edge t:
  - busy=1 in cycles t+1 .. t+N (N = MULT_CYCLES or DIV_CYCLES).
  - New HI/LO are visible on md_out from cycle t+N+1, the first cycle with busy=0.
- MTHI/MTLO at edge t: new value visible in cycle t+1.
- reset asserted mid-BUSY: the operation is discarded and nothing is written to HI/LO.

## Configuration
- MDU_MADD_EN:
  - Defined: MADD/MADDU are accepted as md_start ops with MULT_CYCLES latency. Completion writes {HI,LO} = {HI,LO} + signed (MADD) or unsigned (MADDU) 64-bit product, modulo 2^64. The accumulate uses {HI,LO} as sampled at the accept edge.
  - Undefined: codes 9/10 behave as NONE; md_start with those codes is not accepted.

## Structure
- mdu_pkg holds:
  - md_op encoding constants
  - state encoding
  - MULT_CYCLES/DIV_CYCLES defaults
  - a 4-bit md_op_t typedef
- One sub-module, mdu_calc: combinational computation of the 64-bit {tmp_hi,tmp_lo} from md_op, rs_data, rt_data and current HI/LO, including the div-by-zero and MDU_MADD_EN cases.
- mdu_e keeps the FSM, counter, HI/LO and md_out mux.

## Test plan
- Signed multiply: reset, then MULT rs=0xFFFFFFFE, rt=3 → busy high 5 cycles; afterwards MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA.
- MULTU and divides:
  - MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, busy 10 cycles.
  - DIVU 7/2 → LO=3, HI=1.
- Boundary divides:
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU x/0 with HI=0x11, LO=0x22 preset via MTHI/MTLO → HI/LO unchanged after 10 cycles.
- Cancel and ignore:
  - MULT with exc_cancel=1 → busy stays 0, HI/LO unchanged.
  - MTHI 0x5 with exc_cancel=1 → HI unchanged.
  - md_start during BUSY → ignored; the first result is the one written.
- Reset mid-operation: reset low at cycle 3 of a DIV → busy=0 and HI=LO=0 immediately; after release, MFLO returns 0.
- MDU_MADD_EN defined: preset HI=0, LO=0xFFFFFFFF, then MADDU 1×1 → HI=1, LO=0. Undefined: same stimulus → busy stays 0, HI/LO unchanged.
